// File: rtl/tone_pkg.sv
// tone_pkg: shared types and helpers for the tone arbiter.
// Holds the 2-bit arbiter state encoding, default field widths and the
// gap counter width helper.
package tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } tone_state_e;

    localparam int DEF_FREQ_W = 32;
    localparam int DEF_DUR_W  = 32;

    // Bits needed to hold GAP_CYCLES-1; never less than one bit.
    function automatic int gap_cnt_w(input int gap_cycles);
        int w;
        w = 1;
        while ((32'd1 << w) < gap_cycles) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/tone_prio_enc.sv
// tone_prio_enc: combinational lowest-index-first priority encoder.
// Produces a valid flag, the one-hot winner and its binary index.
module tone_prio_enc #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_vec,
    output logic             o_valid,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    // Isolate the lowest set bit and convert it to a binary index.
    always_comb begin
        o_valid  = |i_vec;
        o_onehot = i_vec & (~i_vec + ONE);
        o_idx    = '0;
        for (int i = 0; i < N; i++) begin
            o_idx = o_idx | (o_onehot[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
    end

endmodule

// File: rtl/tone_arbiter.sv
// tone_arbiter: fixed-priority sharing of one PWM tone generator.
// Index 0 is the highest priority. The winner's frequency and duration are
// latched, the generator enable/done handshake is sequenced and a silent gap
// is inserted after every note.
// Optional feature: define TONE_ARB_PREEMPT_EN to let a higher-priority
// request abort a playing note; without it abort stays low.
module tone_arbiter
    import tone_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int FREQ_W     = DEF_FREQ_W,
    parameter int DUR_W      = DEF_DUR_W,
    parameter int GAP_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*FREQ_W-1:0] req_freq,
    input  logic [NUM_REQ*DUR_W-1:0]  req_dur,
    input  logic                      pause,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        abort,
    output logic                      busy,
    output logic [FREQ_W-1:0]         gen_freq,
    output logic [DUR_W-1:0]          gen_dur,
    output logic                      gen_enable,
    input  logic                      gen_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = gap_cnt_w(GAP_CYCLES);
    // A gap is always at least one cycle, even for GAP_CYCLES of 0 or 1.
    localparam logic [CNT_W-1:0] GAP_LOAD =
        (GAP_CYCLES > 1) ? CNT_W'(GAP_CYCLES - 1) : {CNT_W{1'b0}};

    tone_state_e          r_state;
    logic [IDX_W-1:0]     r_cur_id;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_ack;
    logic [NUM_REQ-1:0]   r_abort;
    logic [FREQ_W-1:0]    r_gen_freq;
    logic [DUR_W-1:0]     r_gen_dur;
    logic [CNT_W-1:0]     r_gap_cnt;

    logic                 w_pick_valid;
    logic [NUM_REQ-1:0]   w_pick_onehot;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_preempt;

    tone_prio_enc #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .i_vec    (req),
        .o_valid  (w_pick_valid),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx)
    );

`ifdef TONE_ARB_PREEMPT_EN
    logic [NUM_REQ-1:0]   w_hi_req;
    logic [NUM_REQ-1:0]   w_pre_onehot;
    logic [IDX_W-1:0]     w_pre_idx;

    // grant is one-hot while playing, so grant-1 masks the indices below it.
    assign w_hi_req = req & (r_grant - {{(NUM_REQ-1){1'b0}}, 1'b1});

    tone_prio_enc #(.N(NUM_REQ), .IDX_W(IDX_W)) u_preempt (
        .i_vec    (w_hi_req),
        .o_valid  (w_preempt),
        .o_onehot (w_pre_onehot),
        .o_idx    (w_pre_idx)
    );
`else
    assign w_preempt = 1'b0;
`endif

    // Arbitration FSM: pick, load, play, then enforced silent gap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cur_id   <= '0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_abort    <= '0;
            r_gen_freq <= '0;
            r_gen_dur  <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_ack   <= '0;
            r_abort <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_cur_id   <= w_pick_idx;
                        r_grant    <= w_pick_onehot;
                        r_gen_freq <= req_freq[int'(w_pick_idx)*FREQ_W +: FREQ_W];
                        r_gen_dur  <= req_dur[int'(w_pick_idx)*DUR_W +: DUR_W];
                        r_state    <= ST_LOAD;
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (r_gen_dur == {DUR_W{1'b0}}) begin
                        // Nothing to play: complete without enabling the generator.
                        r_ack     <= r_grant;
                        r_grant   <= '0;
                        r_gap_cnt <= GAP_LOAD;
                        r_state   <= ST_GAP;
                    end else begin
                        r_state   <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (gen_done && !pause) begin
                        r_ack     <= r_grant;
                        r_grant   <= '0;
                        r_gap_cnt <= GAP_LOAD;
                        r_state   <= ST_GAP;
                    end else if (w_preempt) begin
                        r_abort   <= r_grant;
                        r_grant   <= '0;
                        r_gap_cnt <= GAP_LOAD;
                        r_state   <= ST_GAP;
                    end else if (!req[r_cur_id]) begin
                        r_grant   <= '0;
                        r_gap_cnt <= GAP_LOAD;
                        r_state   <= ST_GAP;
                    end else begin
                        r_state   <= ST_PLAY;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == {CNT_W{1'b0}}) begin
                        r_state   <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Enable follows the state register directly so reset silences at once.
    assign gen_enable = (r_state == ST_PLAY) & ~pause;
    assign busy       = (r_state != ST_IDLE);
    assign grant      = r_grant;
    assign ack        = r_ack;
    assign abort      = r_abort;
    assign gen_freq   = r_gen_freq;
    assign gen_dur    = r_gen_dur;

endmodule

// File: tb/tb_tone_arbiter.sv
// tb_tone_arbiter: directed self-checking bench for tone_arbiter
// (default build, preemption disabled, GAP_CYCLES = 16).
module tb_tone_arbiter;

    logic        clk;
    logic        reset_n;
    logic [2:0]  req;
    logic [95:0] req_freq;
    logic [95:0] req_dur;
    logic        pause;
    logic [2:0]  grant;
    logic [2:0]  ack;
    logic [2:0]  abort;
    logic        busy;
    logic [31:0] gen_freq;
    logic [31:0] gen_dur;
    logic        gen_enable;
    logic        gen_done;

    logic [31:0] f0, f1, f2, d0, d1, d2;

    int n_cmp  = 0;
    int n_fail = 0;

    tone_arbiter #(.NUM_REQ(3), .FREQ_W(32), .DUR_W(32), .GAP_CYCLES(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_freq   (req_freq),
        .req_dur    (req_dur),
        .pause      (pause),
        .grant      (grant),
        .ack        (ack),
        .abort      (abort),
        .busy       (busy),
        .gen_freq   (gen_freq),
        .gen_dur    (gen_dur),
        .gen_enable (gen_enable),
        .gen_done   (gen_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack();
        req_freq = {f2, f1, f0};
        req_dur  = {d2, d1, d0};
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 64) begin
            tick();
            k++;
        end
        check("idle_reached", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = 3'b000;
        pause    = 1'b0;
        gen_done = 1'b0;
        f0 = 32'd1000; f1 = 32'd440; f2 = 32'd880;
        d0 = 32'd0;    d1 = 32'd5;   d2 = 32'd7;
        pack();
        #2;
        check("rst_grant", grant, 3'b000);
        check("rst_ack", ack, 3'b000);
        check("rst_abort", abort, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_enable", gen_enable, 1'b0);
        check("rst_freq", gen_freq, 32'd0);
        check("rst_dur", gen_dur, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single request
        req = 3'b010;
        tick();
        check("single_grant", grant, 3'b010);
        check("single_freq", gen_freq, 32'd440);
        check("single_dur", gen_dur, 32'd5);
        check("single_load_en", gen_enable, 1'b0);
        check("single_busy", busy, 1'b1);
        tick();
        check("single_play_en", gen_enable, 1'b1);
        tick();
        check("single_play_en2", gen_enable, 1'b1);
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        check("single_ack", ack, 3'b010);
        check("single_grant_clr", grant, 3'b000);
        check("single_gap_en", gen_enable, 1'b0);
        req = 3'b000;
        tick();
        check("single_ack_pulse", ack, 3'b000);
        repeat (14) tick();
        check("single_gap_busy", busy, 1'b1);
        tick();
        check("single_idle", busy, 1'b0);

        // Contention: index 1 beats index 2
        req = 3'b110;
        tick();
        check("cont_grant1", grant, 3'b010);
        tick();
        f1 = 32'd123;
        pack();
        tick();
        check("cont_freq_frozen", gen_freq, 32'd440);
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        check("cont_ack1", ack, 3'b010);
        req = 3'b100;
        f1 = 32'd440;
        pack();
        repeat (16) tick();
        check("cont_gap_nogrant", grant, 3'b000);
        tick();
        check("cont_grant2", grant, 3'b100);
        check("cont_freq2", gen_freq, 32'd880);
        tick();
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        check("cont_ack2", ack, 3'b100);
        req = 3'b000;
        wait_idle();

        // Zero duration
        req = 3'b001;
        tick();
        check("zero_grant", grant, 3'b001);
        check("zero_dur", gen_dur, 32'd0);
        check("zero_load_en", gen_enable, 1'b0);
        tick();
        check("zero_ack", ack, 3'b001);
        check("zero_gap_en", gen_enable, 1'b0);
        check("zero_busy", busy, 1'b1);
        req = 3'b000;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("zero_gap_en_loop", gen_enable, 1'b0);
        end
        tick();
        check("zero_idle", busy, 1'b0);

        // Pause with done ignored mid-pause
        req = 3'b010;
        tick();
        tick();
        check("pause_pre_en", gen_enable, 1'b1);
        pause = 1'b1;
        #1;
        check("pause_en_low", gen_enable, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) gen_done = 1'b1;
            else gen_done = 1'b0;
            tick();
            gen_done = 1'b0;
            check("pause_loop_en", gen_enable, 1'b0);
            check("pause_loop_ack", ack, 3'b000);
            check("pause_loop_grant", grant, 3'b010);
        end
        pause = 1'b0;
        #1;
        check("pause_release_en", gen_enable, 1'b1);
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        check("pause_ack", ack, 3'b010);
        req = 3'b000;
        wait_idle();

        // Withdrawal mid-play
        req = 3'b100;
        tick();
        tick();
        tick();
        check("wd_play_en", gen_enable, 1'b1);
        req = 3'b000;
        tick();
        check("wd_grant_clr", grant, 3'b000);
        check("wd_no_ack", ack, 3'b000);
        check("wd_gap_busy", busy, 1'b1);
        check("wd_gap_en", gen_enable, 1'b0);
        wait_idle();

        // Higher-priority request during play: no preemption in this build
        d0 = 32'd3;
        pack();
        req = 3'b100;
        tick();
        tick();
        req = 3'b101;
        tick();
        tick();
        check("np_grant_held", grant, 3'b100);
        check("np_no_abort", abort, 3'b000);
        check("np_freq", gen_freq, 32'd880);
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        check("np_ack2", ack, 3'b100);
        check("np_abort_done", abort, 3'b000);
        req = 3'b001;
        repeat (16) tick();
        tick();
        check("np_grant0", grant, 3'b001);
        check("np_freq0", gen_freq, 32'd1000);
        tick();
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        check("np_ack0", ack, 3'b001);
        req = 3'b000;
        wait_idle();

        // Asynchronous reset mid-play
        req = 3'b100;
        tick();
        tick();
        check("rst_mid_en_pre", gen_enable, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_en", gen_enable, 1'b0);
        check("rst_mid_grant", grant, 3'b000);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_freq", gen_freq, 32'd0);
        check("rst_mid_dur", gen_dur, 32'd0);
        req = 3'b000;
        tick();
        reset_n = 1'b1;
        tick();
        check("rst_after_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
